// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer-width helper and status-register bit positions.
package fifo_pkg;

  // Bits needed to index 0..n-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Bit positions of the FIFO status word in the APB register map.
  localparam int unsigned FifoStEmpty = 0;
  localparam int unsigned FifoStFull  = 1;
  localparam int unsigned FifoStAe    = 2;
  localparam int unsigned FifoStAf    = 3;
  localparam int unsigned FifoStOvf   = 4;
  localparam int unsigned FifoStUnf   = 5;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO pointer: increments on en_i, wraps DEPTH-1 -> 0, synchronous clear.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins, explicit wrap so non-power-of-2 depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable thresholds, sticky errors and FWFT/registered read port.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 16,
  parameter int unsigned  FWFT  = 1,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o,
  input  logic [AW:0]      ae_thresh_i,
  input  logic [AW:0]      af_thresh_i,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  input  logic             err_clr_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      level_q, level_d;
  logic             empty_q, full_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             op_en, acc_rd, acc_wr, rej_rd, rej_wr;

  // Accept/reject decode; clear suppresses both ports for the cycle.
  always_comb begin
    op_en  = enable_i & ~clear_i;
    acc_rd = op_en & read_i & ~empty_q;
    acc_wr = op_en & write_i & (~full_q | acc_rd);
    rej_rd = op_en & read_i & empty_q;
    rej_wr = op_en & write_i & ~acc_wr;
  end

  // Next level and sticky flags; a new error beats a coincident err_clr.
  always_comb begin
    level_d = level_q;
    if (clear_i) begin
      level_d = '0;
    end else if (acc_wr && !acc_rd) begin
      level_d = level_q + (AW + 1)'(1);
    end else if (acc_rd && !acc_wr) begin
      level_d = level_q - (AW + 1)'(1);
    end
    ovf_d = err_clr_i ? 1'b0 : ovf_q;
    unf_d = err_clr_i ? 1'b0 : unf_q;
    if (rej_wr) ovf_d = 1'b1;
    if (rej_rd) unf_d = 1'b1;
  end

  // Status registers, frozen while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (enable_i) begin
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == (AW + 1)'(DEPTH));
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are deliberately not reset or cleared.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem_q[wr_ptr] <= wdata_i;
    end
  end

  fifo_ptr_wrap #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (acc_wr),
    .clr_i   (enable_i & clear_i),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr_wrap #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (acc_rd),
    .clr_i   (enable_i & clear_i),
    .ptr_o   (rd_ptr)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; driven to 0 while empty so reset value is defined.
    always_comb begin
      rdata_o  = empty_q ? '0 : mem_q[rd_ptr];
      rvalid_o = ~empty_q;
    end
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Registered read: data and one-cycle valid pulse after an accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= acc_rd;
        if (acc_rd) begin
          rdata_q <= mem_q[rd_ptr];
        end
      end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
  end

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign almost_empty_o = (level_q <= ae_thresh_i);
  assign almost_full_o  = (level_q >= af_thresh_i);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: DEPTH=5 in FWFT and registered-read flavours.
module tb_sync_fifo_prog;

  localparam int unsigned W = 8;
  localparam int unsigned D = 5;

  typedef struct {
    logic         wr;
    logic [7:0]   wd;
    logic         rd;
    logic         ec;
    int unsigned  lvl;
    logic         ovf;
    logic         unf;
    logic         chk;
    logic [7:0]   erd;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, clear, write, read, err_clr;
  logic [W-1:0] wdata;
  logic [3:0]   ae_thresh, af_thresh;

  logic [W-1:0] rdata1, rdata2;
  logic         rvalid1, rvalid2, empty1, empty2, full1, full2;
  logic [3:0]   level1, level2;
  logic         ae1, ae2, af1, af2, ovf1, ovf2, unf1, unf2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_dut_fwft (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .write_i        (write),
    .wdata_i        (wdata),
    .read_i         (read),
    .rdata_o        (rdata1),
    .rvalid_o       (rvalid1),
    .empty_o        (empty1),
    .full_o         (full1),
    .level_o        (level1),
    .ae_thresh_i    (ae_thresh),
    .af_thresh_i    (af_thresh),
    .almost_empty_o (ae1),
    .almost_full_o  (af1),
    .err_clr_i      (err_clr),
    .overflow_o     (ovf1),
    .underflow_o    (unf1)
  );

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut_reg (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .write_i        (write),
    .wdata_i        (wdata),
    .read_i         (read),
    .rdata_o        (rdata2),
    .rvalid_o       (rvalid2),
    .empty_o        (empty2),
    .full_o         (full2),
    .level_o        (level2),
    .ae_thresh_i    (ae_thresh),
    .af_thresh_i    (af_thresh),
    .almost_empty_o (ae2),
    .almost_full_o  (af2),
    .err_clr_i      (err_clr),
    .overflow_o     (ovf2),
    .underflow_o    (unf2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive all inputs at the falling edge, then let combinational outputs settle.
  task automatic set_in(input logic wr, input logic [7:0] wd, input logic rd, input logic en,
                        input logic clr, input logic ec);
    @(negedge clk);
    write = wr; wdata = wd; read = rd; enable = en; clear = clr; err_clr = ec;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic en,
                      input logic clr, input logic ec);
    set_in(wr, wd, rd, en, clr, ec);
    tick();
  endtask

  // Read one word, checking the FWFT head before the clock edge.
  task automatic rd_chk(input string nm, input logic [7:0] exp);
    set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check(nm, rdata1, exp);
    tick();
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                              input logic ec, input int unsigned lvl, input logic ovf,
                              input logic unf, input logic chk, input logic [7:0] erd);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.ec = ec; v.lvl = lvl;
    v.ovf = ovf; v.unf = unf; v.chk = chk; v.erd = erd;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0;
    err_clr = 1'b0; wdata = '0; ae_thresh = 4'd1; af_thresh = 4'd4;

    // Fill/overflow/drain, full+rw, empty+rw, err_clr; thresholds ae=1, af=4.
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 8'hA0 + 8'(i), 0, 0, i + 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 8'hA5, 0, 0, 5, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 0, 1, 0, 4 - i, 1, 0, 1, 8'hA0 + 8'(i)));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 8'hB0 + 8'(i), 0, 0, i + 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 8'hC0, 1, 0, 5, 0, 0, 1, 8'hB0));
    for (int i = 1; i < 5; i++) vq.push_back(mk(0, 0, 1, 0, 5 - i, 0, 0, 1, 8'hB0 + 8'(i)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 8'hC0));
    vq.push_back(mk(1, 8'hD0, 1, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 8'hD0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Reset state.
    #12;
    check("rst_level", 32'(level1), 0);
    check("rst_empty", 32'(empty1), 1);
    check("rst_full", 32'(full1), 0);
    check("rst_ovf", 32'(ovf1), 0);
    check("rst_unf", 32'(unf1), 0);
    check("rst_rdata", 32'(rdata1), 0);
    check("rst_rvalid_reg", 32'(rvalid2), 0);
    check("rst_rdata_reg", 32'(rdata2), 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      set_in(vq[i].wr, vq[i].wd, vq[i].rd, 1'b1, 1'b0, vq[i].ec);
      if (vq[i].chk) check($sformatf("v%0d_rdata", i), 32'(rdata1), 32'(vq[i].erd));
      tick();
      check($sformatf("v%0d_level", i), 32'(level1), vq[i].lvl);
      check($sformatf("v%0d_empty", i), 32'(empty1), 32'(vq[i].lvl == 0));
      check($sformatf("v%0d_full", i), 32'(full1), 32'(vq[i].lvl == D));
      check($sformatf("v%0d_rvalid", i), 32'(rvalid1), 32'(vq[i].lvl != 0));
      check($sformatf("v%0d_ovf", i), 32'(ovf1), 32'(vq[i].ovf));
      check($sformatf("v%0d_unf", i), 32'(unf1), 32'(vq[i].unf));
      check($sformatf("v%0d_ae", i), 32'(ae1), 32'(vq[i].lvl <= 1));
      check($sformatf("v%0d_af", i), 32'(af1), 32'(vq[i].lvl >= 4));
    end
    step(0, 0, 0, 1, 0, 0);

    // Pointer wrap: 3 writes then 3 reads, four rounds.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1, 8'hE0 + 8'(3 * k + i), 0, 1, 0, 0);
        check($sformatf("wrap%0d_wlvl%0d", k, i), 32'(level1), i + 1);
      end
      for (int i = 0; i < 3; i++) begin
        rd_chk($sformatf("wrap%0d_rd%0d", k, i), 8'hE0 + 8'(3 * k + i));
        check($sformatf("wrap%0d_rlvl%0d", k, i), 32'(level1), 2 - i);
      end
    end
    step(0, 0, 0, 1, 0, 0);

    // Live threshold changes.
    for (int i = 0; i < 4; i++) step(1, 8'hF0 + 8'(i), 0, 1, 0, 0);
    check("thr_af_at4", 32'(af1), 1);
    check("thr_ae_at4", 32'(ae1), 0);
    af_thresh = 4'd7;
    ae_thresh = 4'd5;
    #1;
    check("thr_af7", 32'(af1), 0);
    check("thr_ae5", 32'(ae1), 1);
    af_thresh = 4'd4;
    ae_thresh = 4'd1;

    // Overflow, then clear with write asserted keeps sticky flags.
    step(1, 8'hF4, 0, 1, 0, 0);
    step(1, 8'hF5, 0, 1, 0, 0);
    check("clr_pre_ovf", 32'(ovf1), 1);
    rd_chk("clr_rd0", 8'hF0);
    rd_chk("clr_rd1", 8'hF1);
    check("clr_pre_lvl", 32'(level1), 3);
    step(1, 8'h99, 0, 1, 1, 0);
    check("clr_level", 32'(level1), 0);
    check("clr_empty", 32'(empty1), 1);
    check("clr_full", 32'(full1), 0);
    check("clr_ovf_kept", 32'(ovf1), 1);
    step(0, 0, 1, 1, 0, 0);
    check("clr_unf", 32'(unf1), 1);
    check("clr_lvl_after_rd", 32'(level1), 0);
    step(0, 0, 0, 1, 0, 1);
    check("errclr_ovf", 32'(ovf1), 0);
    check("errclr_unf", 32'(unf1), 0);

    // Registered read port and enable freeze.
    step(1, 8'h11, 0, 1, 0, 0);
    step(1, 8'h22, 0, 1, 0, 0);
    check("reg_lvl2", 32'(level2), 2);
    step(0, 0, 1, 1, 0, 0);
    check("reg_rvalid1", 32'(rvalid2), 1);
    check("reg_rdata1", 32'(rdata2), 32'h11);
    check("reg_lvl1", 32'(level2), 1);
    step(0, 0, 0, 1, 0, 0);
    check("reg_rvalid_idle", 32'(rvalid2), 0);
    check("reg_rdata_hold", 32'(rdata2), 32'h11);
    step(1, 8'h77, 1, 0, 0, 0);
    check("en0_lvl", 32'(level2), 1);
    check("en0_rvalid", 32'(rvalid2), 0);
    check("en0_fwft_lvl", 32'(level1), 1);
    step(0, 0, 1, 1, 0, 0);
    check("reg_rvalid2", 32'(rvalid2), 1);
    check("reg_rdata2", 32'(rdata2), 32'h22);
    check("reg_lvl0", 32'(level2), 0);
    check("fwft_rvalid_empty", 32'(rvalid1), 0);

    // Asynchronous reset mid-burst.
    step(0, 0, 1, 1, 0, 0);
    check("burst_unf", 32'(unf1), 1);
    step(1, 8'h33, 0, 1, 0, 0);
    step(1, 8'h44, 1, 1, 0, 0);
    set_in(1, 8'h55, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(level1), 0);
    check("mid_rst_empty", 32'(empty1), 1);
    check("mid_rst_unf", 32'(unf1), 0);
    check("mid_rst_rdata", 32'(rdata1), 0);
    check("mid_rst_rdata_reg", 32'(rdata2), 0);
    check("mid_rst_rvalid_reg", 32'(rvalid2), 0);
    check("mid_rst_level_reg", 32'(level2), 0);
    step(0, 0, 0, 1, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
